pipeline_hazard_ctrl: RTL and testbench

Parametrised stall/flush controller for an N-stage out-of-order pipeline. It generates per-stage stall and flush vectors from I-cache, D-cache, ROB and branch-resolution events. Unlike the single-cycle combinational stall generator, it keeps sequential state:
- ROB occupancy, tracked internally from alloc/retire/squash counts.
- Outstanding D-cache misses.
- A mispredict flush/refill FSM.

It sits beside the fetch/rename/dispatch/issue/execute stages and drives their stall and flush inputs.

---
 rtl/hazard_pkg.sv | 21 ++
 rtl/pipeline_hazard_ctrl_counter.sv | 52 +++++
 rtl/pipeline_hazard_ctrl.sv | 147 ++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and stage-index helpers for the pipeline hazard controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        CTRL_RUN    = 2'd0,
        CTRL_FLUSH  = 2'd1,
        CTRL_REFILL = 2'd2
    } ctrl_state_t;

    localparam int unsigned STG_FETCH = 0;

    // Dispatch and backend positions depend on the pipeline depth.
    function automatic int unsigned stg_dispatch(input int unsigned num_stages);
        return num_stages - 2;
    endfunction

    function automatic int unsigned stg_backend(input int unsigned num_stages);
        return num_stages - 1;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_counter.sv
// Saturating up/down occupancy counter with a sticky over/underflow flag.
module sat_updown_counter #(
    parameter int unsigned MAX   = 16,
    parameter int unsigned INC_W = 2,
    parameter int unsigned DEC_W = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [INC_W-1:0]           inc,
    input  logic [DEC_W-1:0]           dec,
    output logic [$clog2(MAX+1)-1:0]   count,
    output logic                       error
);

    localparam int unsigned CW  = $clog2(MAX + 1);
    localparam int unsigned MW  = (CW > INC_W) ? CW : INC_W;
    localparam int unsigned SW  = ((MW > DEC_W) ? MW : DEC_W) + 2;
    localparam logic signed [SW-1:0] MAX_S = SW'(MAX);

    logic [CW-1:0]        count_q, count_d;
    logic                 error_q, error_d;
    logic signed [SW-1:0] sum;

    always_comb begin
        sum     = $signed(SW'(count_q)) + $signed(SW'(inc)) - $signed(SW'(dec));
        count_d = count_q;
        error_d = error_q;
        if (sum < 0) begin
            count_d = '0;
            error_d = 1'b1;
        end else if (sum > MAX_S) begin
            count_d = CW'(MAX);
            error_d = 1'b1;
        end else begin
            count_d = sum[CW-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            error_q <= 1'b0;
        end else begin
            count_q <= count_d;
            error_q <= error_d;
        end
    end

    assign count = count_q;
    assign error = error_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller: ROB and miss occupancy tracking plus a mispredict flush/refill FSM.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned NUM_STAGES     = 5,
    parameter int unsigned ROB_SIZE       = 16,
    parameter int unsigned DISPATCH_WIDTH = 2,
    parameter int unsigned RETIRE_WIDTH   = 2,
    parameter int unsigned MAX_MISSES     = 4,
    parameter int unsigned FLUSH_CYCLES   = 2
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  icache_busy,
    input  logic                                  icache_overwrite_pc,
    input  logic                                  icache_valid,
    input  logic                                  dcache_busy,
    input  logic                                  dcache_miss,
    input  logic                                  dcache_fill,
    input  logic [$clog2(DISPATCH_WIDTH+1)-1:0]   rob_alloc,
    input  logic [$clog2(RETIRE_WIDTH+1)-1:0]     rob_retire,
    input  logic                                  mispredict,
    input  logic [$clog2(ROB_SIZE+1)-1:0]         rob_squash,
    output logic [NUM_STAGES-1:0]                 stall,
    output logic [NUM_STAGES-1:0]                 flush,
    output logic [$clog2(ROB_SIZE+1)-1:0]         rob_count,
    output logic                                  rob_full,
    output logic [$clog2(MAX_MISSES+1)-1:0]       miss_count,
    output logic [1:0]                            ctrl_state,
    output logic                                  error
);

    localparam int unsigned RC_W         = $clog2(ROB_SIZE + 1);
    localparam int unsigned AW           = $clog2(DISPATCH_WIDTH + 1);
    localparam int unsigned MC_W         = $clog2(MAX_MISSES + 1);
    localparam int unsigned FCW          = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FCW-1:0] RELOAD    = FCW'(FLUSH_CYCLES - 1);
    localparam int unsigned STG_DISPATCH = stg_dispatch(NUM_STAGES);
    localparam int unsigned STG_BACKEND  = stg_backend(NUM_STAGES);

    ctrl_state_t      state_q, state_d;
    logic [FCW-1:0]   cnt_q, cnt_d;
    logic [RC_W:0]    rob_dec;
    logic             rob_err, miss_err;
    logic             near_full, miss_sat, in_flush;
    logic [NUM_STAGES-1:0] stall_raw, flush_vec;

    // Retirement and squash both drain the ROB; squash only counts with a mispredict.
    assign rob_dec = (RC_W+1)'(rob_retire) + (mispredict ? (RC_W+1)'(rob_squash) : '0);

    sat_updown_counter #(
        .MAX   (ROB_SIZE),
        .INC_W (AW),
        .DEC_W (RC_W + 1)
    ) u_rob_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (rob_alloc),
        .dec   (rob_dec),
        .count (rob_count),
        .error (rob_err)
    );

    sat_updown_counter #(
        .MAX   (MAX_MISSES),
        .INC_W (1),
        .DEC_W (1)
    ) u_miss_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (dcache_miss),
        .dec   (dcache_fill),
        .count (miss_count),
        .error (miss_err)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            CTRL_RUN: begin
                if (mispredict) begin
                    state_d = CTRL_FLUSH;
                    cnt_d   = RELOAD;
                end
            end
            CTRL_FLUSH: begin
                if (mispredict) begin
                    cnt_d = RELOAD;
                end else if (cnt_q == '0) begin
                    state_d = CTRL_REFILL;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            CTRL_REFILL: begin
                if (mispredict) begin
                    state_d = CTRL_FLUSH;
                    cnt_d   = RELOAD;
                end else begin
                    state_d = CTRL_RUN;
                end
            end
            default: begin
                state_d = CTRL_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= CTRL_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_flush  = (state_q == CTRL_FLUSH);
    assign near_full = (32'(rob_count) + DISPATCH_WIDTH) > ROB_SIZE;
    assign miss_sat  = (miss_count == MC_W'(MAX_MISSES));

    // Stalls ripple from the backend toward fetch; flushed stages never also stall.
    always_comb begin
        stall_raw = '0;
        flush_vec = '0;
        for (int unsigned i = 1; i <= STG_DISPATCH; i++) begin
            flush_vec[i] = in_flush;
        end
        stall_raw[STG_BACKEND]  = reset | dcache_busy | dcache_miss | miss_sat;
        stall_raw[STG_DISPATCH] = reset | near_full | stall_raw[STG_BACKEND];
        for (int unsigned i = STG_DISPATCH - 1; i >= 1; i--) begin
            stall_raw[i] = reset | stall_raw[i+1];
        end
        stall_raw[STG_FETCH] = in_flush | reset | icache_busy | icache_overwrite_pc
                             | !icache_valid | stall_raw[1];
    end

    assign stall      = stall_raw & ~flush_vec;
    assign flush      = flush_vec;
    assign rob_full   = (rob_count == RC_W'(ROB_SIZE));
    assign ctrl_state = state_q;
    assign error      = rob_err | miss_err;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench: directed scenarios plus random traffic against an occupancy/flush-timer model.
module tb_pipeline_hazard_ctrl;

    localparam int NS = 5;
    localparam int RS = 16;
    localparam int DW = 2;
    localparam int RW = 2;
    localparam int MM = 4;
    localparam int FC = 2;

    logic clk = 1'b0;
    logic reset;
    logic icache_busy, icache_overwrite_pc, icache_valid;
    logic dcache_busy, dcache_miss, dcache_fill;
    logic [$clog2(DW+1)-1:0] rob_alloc;
    logic [$clog2(RW+1)-1:0] rob_retire;
    logic mispredict;
    logic [$clog2(RS+1)-1:0] rob_squash;
    logic [NS-1:0] stall, flush;
    logic [$clog2(RS+1)-1:0] rob_count;
    logic rob_full;
    logic [$clog2(MM+1)-1:0] miss_count;
    logic [1:0] ctrl_state;
    logic error;

    pipeline_hazard_ctrl #(
        .NUM_STAGES     (NS),
        .ROB_SIZE       (RS),
        .DISPATCH_WIDTH (DW),
        .RETIRE_WIDTH   (RW),
        .MAX_MISSES     (MM),
        .FLUSH_CYCLES   (FC)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .icache_busy         (icache_busy),
        .icache_overwrite_pc (icache_overwrite_pc),
        .icache_valid        (icache_valid),
        .dcache_busy         (dcache_busy),
        .dcache_miss         (dcache_miss),
        .dcache_fill         (dcache_fill),
        .rob_alloc           (rob_alloc),
        .rob_retire          (rob_retire),
        .mispredict          (mispredict),
        .rob_squash          (rob_squash),
        .stall               (stall),
        .flush               (flush),
        .rob_count           (rob_count),
        .rob_full            (rob_full),
        .miss_count          (miss_count),
        .ctrl_state          (ctrl_state),
        .error               (error)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Reference model: plain integer occupancies and a "flush cycles remaining" timer.
    int m_rob, m_miss, m_fl_left;
    bit m_refill, m_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [NS-1:0] exp_stall();
        logic [NS-1:0] s;
        s = '0;
        if (reset) return '1;
        if (dcache_busy || dcache_miss || m_miss == MM) s = '1;
        if (m_rob + DW > RS) s[NS-2:0] = '1;
        if (icache_busy || icache_overwrite_pc || !icache_valid) s[0] = 1'b1;
        if (m_fl_left > 0) begin
            s[NS-2:1] = '0;
            s[0] = 1'b1;
        end
        return s;
    endfunction

    function automatic logic [NS-1:0] exp_flush();
        logic [NS-1:0] f;
        f = '0;
        if (m_fl_left > 0) f[NS-2:1] = '1;
        return f;
    endfunction

    function automatic logic [1:0] exp_state();
        if (m_fl_left > 0) return 2'd1;
        if (m_refill) return 2'd2;
        return 2'd0;
    endfunction

    task automatic model_clear();
        m_rob = 0; m_miss = 0; m_fl_left = 0; m_refill = 0; m_err = 0;
    endtask

    task automatic idle();
        icache_busy = 0; icache_overwrite_pc = 0; icache_valid = 1;
        dcache_busy = 0; dcache_miss = 0; dcache_fill = 0;
        rob_alloc = '0; rob_retire = '0; mispredict = 0; rob_squash = '0;
    endtask

    // One clock: compare mid-cycle, then advance the model on the edge.
    task automatic cyc();
        int nr;
        @(negedge clk);
        check("stall", stall, exp_stall());
        check("flush", flush, exp_flush());
        check("rob_count", rob_count, m_rob);
        check("rob_full", rob_full, m_rob == RS);
        check("miss_count", miss_count, m_miss);
        check("ctrl_state", ctrl_state, exp_state());
        check("error", error, m_err);
        @(posedge clk);
        if (reset) begin
            model_clear();
        end else begin
            nr = m_rob + int'(rob_alloc) - int'(rob_retire) - (mispredict ? int'(rob_squash) : 0);
            if (nr < 0) begin nr = 0; m_err = 1; end
            if (nr > RS) begin nr = RS; m_err = 1; end
            m_rob = nr;
            if (dcache_miss && !dcache_fill) begin
                if (m_miss == MM) m_err = 1; else m_miss++;
            end else if (dcache_fill && !dcache_miss) begin
                if (m_miss == 0) m_err = 1; else m_miss--;
            end
            if (mispredict) begin
                m_fl_left = FC;
                m_refill = 0;
            end else if (m_fl_left > 0) begin
                m_fl_left--;
                m_refill = (m_fl_left == 0);
            end else begin
                m_refill = 0;
            end
        end
        #1;
    endtask

    task automatic do_reset(input int n);
        reset = 1;
        model_clear();
        repeat (n) cyc();
        reset = 0;
    endtask

    initial begin
        idle();
        do_reset(3);
        check("rst_rob", rob_count, 0);
        check("rst_miss", miss_count, 0);
        check("rst_state", ctrl_state, 0);
        check("rst_flush", flush, 0);
        check("rst_err", error, 0);

        // Fill the ROB two at a time, then retire
        rob_alloc = 2;
        repeat (7) cyc();
        idle();
        check("rob14", rob_count, 14);
        rob_retire = 2;
        cyc();
        idle();
        check("rob12", rob_count, 12);
        check("rob12_stall", stall[3:0], 4'b0000);

        // Mispredict, re-mispredict on last FLUSH cycle, mispredict in REFILL
        mispredict = 1; rob_squash = 5;
        cyc();
        idle();
        check("sq_rob7", rob_count, 7);
        check("sq_state", ctrl_state, 1);
        check("sq_flush", flush, 5'b01110);
        check("sq_stall0", stall[0], 1);
        cyc();
        mispredict = 1;
        cyc();
        idle();
        check("ext_state", ctrl_state, 1);
        cyc();
        cyc();
        check("refill", ctrl_state, 2);
        mispredict = 1;
        cyc();
        idle();
        check("refill_mp", ctrl_state, 1);
        repeat (3) cyc();
        check("back_run", ctrl_state, 0);

        // Miss saturation and overflow
        dcache_miss = 1;
        repeat (4) cyc();
        idle();
        check("miss4", miss_count, 4);
        check("miss_sat_stall", stall, 5'b11111);
        dcache_miss = 1; dcache_fill = 1;
        cyc();
        idle();
        check("miss_hold", miss_count, 4);
        check("miss_hold_err", error, 0);
        dcache_miss = 1;
        cyc();
        idle();
        check("miss_ovf_err", error, 1);
        check("miss_ovf_cnt", miss_count, 4);

        // Fill underflow
        do_reset(2);
        dcache_fill = 1;
        cyc();
        idle();
        check("fill_unf_err", error, 1);
        check("fill_unf_cnt", miss_count, 0);

        // Asynchronous reset in the middle of FLUSH
        do_reset(2);
        mispredict = 1;
        cyc();
        idle();
        check("pre_async", ctrl_state, 1);
        #2;
        reset = 1;
        #1;
        check("async_state", ctrl_state, 0);
        check("async_flush", flush, 0);
        check("async_stall", stall, 5'b11111);
        model_clear();
        cyc();
        reset = 0;
        cyc();

        // Random traffic, re-reset periodically so sticky error doesn't mask everything
        for (int blk = 0; blk < 4; blk++) begin
            do_reset(1);
            for (int k = 0; k < 100; k++) begin
                rob_alloc           = 2'($urandom_range(0, DW));
                rob_retire          = 2'($urandom_range(0, RW));
                mispredict          = ($urandom_range(0, 9) == 0);
                rob_squash          = 5'($urandom_range(0, 8));
                dcache_miss         = ($urandom_range(0, 2) == 0);
                dcache_fill         = ($urandom_range(0, 2) == 0);
                dcache_busy         = ($urandom_range(0, 9) == 0);
                icache_busy         = ($urandom_range(0, 9) == 0);
                icache_overwrite_pc = ($urandom_range(0, 9) == 0);
                icache_valid        = ($urandom_range(0, 9) != 0);
                cyc();
            end
            idle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
